// File: rtl/id_operand_stage.sv
// ---------------------------------------------------------------------------
// id_operand_stage
//
// Decode-stage slot of the 5-stage pipeline, sitting between IF and EXE.
// It holds one instruction bundle, drives the register-file read addresses
// from that bundle and resolves both source operands through a priority
// bypass network fed by NUM_FWD downstream producer stages. The slot stalls
// only when the youngest matching producer has not produced its result yet
// (load-use), honours a flush from later stages and counts stall cycles.
//
// Parameters:
//   DW       operand / register data width
//   AW       register address width
//   NUM_FWD  number of bypass sources; index 0 is the youngest (EXE)
//   CW       stall counter width
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_allowin      handshake with IF
//   in_pc, in_inst             incoming instruction PC and word
//   in_ren                     source-read enables {src2, src1}
//   in_raddr1, in_raddr2       incoming source register numbers
//   rf_raddr1/2, rf_rdata1/2   register file read port (combinational read)
//   fwd_we, fwd_ready          per producer: writes a GPR / result available
//   fwd_addr, fwd_data         per producer destination and result, packed
//                              at [i*AW +: AW] and [i*DW +: DW]
//   flush                      kill the held bundle and drop any incoming one
//   out_valid / out_allowin    handshake with EXE
//   out_pc, out_inst           held PC and instruction word
//   out_src1, out_src2         resolved operands
//   stall_cnt                  saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module id_operand_stage #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NUM_FWD = 3,
    parameter int CW      = 16
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_valid,
    output logic                    in_allowin,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_inst,
    input  logic [1:0]              in_ren,
    input  logic [AW-1:0]           in_raddr1,
    input  logic [AW-1:0]           in_raddr2,

    output logic [AW-1:0]           rf_raddr1,
    output logic [AW-1:0]           rf_raddr2,
    input  logic [DW-1:0]           rf_rdata1,
    input  logic [DW-1:0]           rf_rdata2,

    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [NUM_FWD*AW-1:0]   fwd_addr,
    input  logic [NUM_FWD*DW-1:0]   fwd_data,

    input  logic                    flush,

    output logic                    out_valid,
    input  logic                    out_allowin,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_inst,
    output logic [DW-1:0]           out_src1,
    output logic [DW-1:0]           out_src2,
    output logic [CW-1:0]           stall_cnt
);

    // ------------------------------------------------------------------
    // Held bundle
    // ------------------------------------------------------------------
    logic              valid_q;
    logic [31:0]       pc_q;
    logic [31:0]       inst_q;
    logic [1:0]        ren_q;
    logic [AW-1:0]     raddr1_q;
    logic [AW-1:0]     raddr2_q;
    logic [CW-1:0]     stall_cnt_q;

    logic              blocked1;
    logic              blocked2;
    logic              ready_go;
    logic              load_bundle;
    logic              stall_cycle;

    // ------------------------------------------------------------------
    // Operand resolution for one source.
    // Returns {blocked, operand}. The youngest producer writing the
    // source register decides: its result if ready, otherwise the source
    // is blocked and older producers are not consulted. r0 always reads
    // as zero and never waits on a producer.
    // ------------------------------------------------------------------
    function automatic logic [DW:0] resolve_src(
        input logic                  ren,
        input logic [AW-1:0]         raddr,
        input logic [DW-1:0]         rdata,
        input logic [NUM_FWD-1:0]    we,
        input logic [NUM_FWD-1:0]    rdy,
        input logic [NUM_FWD*AW-1:0] addr,
        input logic [NUM_FWD*DW-1:0] data
    );
        logic          found;
        logic          blocked;
        logic [DW-1:0] value;
        found   = 1'b0;
        blocked = 1'b0;
        value   = rdata;
        if (ren) begin
            if (raddr == '0) begin
                value = '0;
            end else begin
                // Scan youngest first; the first match shadows the rest.
                for (int i = 0; i < NUM_FWD; i++) begin
                    if (!found && we[i] && (addr[i*AW +: AW] == raddr)) begin
                        found = 1'b1;
                        if (rdy[i]) begin
                            value = data[i*DW +: DW];
                        end else begin
                            blocked = 1'b1;
                        end
                    end
                end
            end
        end
        return {blocked, value};
    endfunction

    // NOTE: every signal driven here gets a value on every path (defaults
    // first), so no latch is inferred.
    always_comb begin
        logic [DW:0] r1;
        logic [DW:0] r2;
        r1 = resolve_src(ren_q[0], raddr1_q, rf_rdata1,
                         fwd_we, fwd_ready, fwd_addr, fwd_data);
        r2 = resolve_src(ren_q[1], raddr2_q, rf_rdata2,
                         fwd_we, fwd_ready, fwd_addr, fwd_data);
        blocked1 = r1[DW];
        blocked2 = r2[DW];
        out_src1 = r1[DW-1:0];
        out_src2 = r2[DW-1:0];
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign ready_go    = ~(blocked1 | blocked2);
    assign out_valid   = valid_q & ready_go & ~flush;
    assign in_allowin  = ~valid_q | (ready_go & out_allowin);
    assign load_bundle = in_valid & in_allowin & ~flush;
    assign stall_cycle = valid_q & ~ready_go & ~flush;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_allowin) begin
            valid_q <= in_valid;
        end
    end

    // NOTE: the payload carries no reset; valid_q qualifies it, and leaving
    // it unreset keeps the reset net off these wide datapath registers.
    always_ff @(posedge clk) begin
        if (load_bundle) begin
            pc_q     <= in_pc;
            inst_q   <= in_inst;
            ren_q    <= in_ren;
            raddr1_q <= in_raddr1;
            raddr2_q <= in_raddr2;
        end
    end

    // Saturating hazard-stall counter: a flushed stall cycle is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_cycle && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign rf_raddr1 = raddr1_q;
    assign rf_raddr2 = raddr2_q;
    assign out_pc    = pc_q;
    assign out_inst  = inst_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised decode-stage slot that sits between IF and EXE in the 5-stage pipeline.
- Holds one instruction bundle and reads the register file.
- Resolves source operands through a priority bypass network fed by NUM_FWD downstream stages, instead of stalling on every RAW hazard.
- Stalls only on unready producers (load-use), honours a flush from later stages, and counts stall cycles.

Parameters:
DW, 32, register/operand data width
AW, 5, register address width
NUM_FWD, 3, number of bypass sources; index 0 = youngest (EXE), then MEM, WB
CW, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  IF bundle valid
in_allowin  out  1  slot can accept a bundle this cycle
in_pc  in  32  instruction PC
in_inst  in  32  instruction word
in_ren  in  2  source-read enables {src2, src1}
in_raddr1  in  AW  source 1 register number
in_raddr2  in  AW  source 2 register number
rf_raddr1  out  AW  regfile read address 1 (from held bundle)
rf_raddr2  out  AW  regfile read address 2
rf_rdata1  in  DW  regfile read data 1 (combinational read)
rf_rdata2  in  DW  regfile read data 2
fwd_we  in  NUM_FWD  producer stage i valid and writes a GPR
fwd_ready  in  NUM_FWD  producer stage i result is available
fwd_addr  in  NUM_FWD*AW  dest of stage i at [i*AW +: AW]
fwd_data  in  NUM_FWD*DW  result of stage i at [i*DW +: DW]
flush  in  1  kill held bundle (branch/exception from later stage)
out_valid  out  1  bundle valid to EXE
out_allowin  in  1  EXE can accept
out_pc  out  32  held PC
out_inst  out  32  held instruction
out_src1  out  DW  resolved operand 1
out_src2  out  DW  resolved operand 2
stall_cnt  out  CW  saturating count of hazard-stall cycles

Behaviour:
- Reset: valid=0, stall_cnt=0. out_valid=0 and in_allowin=1 in the cycle after reset.
- Payload registers {pc, inst, ren, raddr1, raddr2} are not reset.
- Payload loads when in_valid & in_allowin & ~flush.
- valid next-state:
  - reset -> 0;
  - else flush -> 0 (incoming bundle dropped);
  - else in_allowin -> in_valid;
  - else hold.
- Per source s (1, 2): hit_i = ren_s & fwd_we[i] & (fwd_addr_i == raddr_s) & (raddr_s != 0).
- The lowest index i with hit_i wins.
  - If fwd_ready[i] = 1, operand = fwd_data_i.
  - If fwd_ready[i] = 0, the source is blocked; older matches are ignored.
- No hit: operand = rf_rdata_s. raddr_s == 0: operand = 0 regardless of rf_rdata.
- ren_s = 0: operand = rf_rdata_s, never blocked.
- ready_go = ~(blocked1 | blocked2).
- out_valid = valid & ready_go & ~flush.
- in_allowin = ~valid | (ready_go & out_allowin).
- Latency:
  - 1 cycle IF->EXE with no hazard.
  - Operands are recomputed combinationally every cycle while held, so a producer becoming ready releases the stall in that same cycle.
- Back-pressure: with out_allowin = 0 the bundle holds, out_valid may stay 1, and in_allowin = 0.
- stall_cnt increments by 1 in each cycle with valid & ~ready_go & ~flush. It saturates at 2^CW-1 and never wraps.
- Simultaneous events:
  - flush + in_valid in the same cycle: drop.
  - flush + stall: slot empties, no count.
  - Reset mid-stall: slot empties; the counter clears to 0.

Test Plan:
1. Basic pass-through: regfile r3=0x11, r4=0x22, no fwd; `add r5,r3,r4` -> 1 cycle later out_valid=1, src1=0x11, src2=0x22, stall_cnt=0.
2. Bypass priority: fwd_we=3'b111, all three stages target r3 with data 0xA/0xB/0xC, all ready -> src1=0xA. Drop stage0 -> src1=0xB.
3. Load-use: stage0 targets r3 with fwd_ready=0 for 2 cycles, stage1 also matches r3 ready -> out_valid=0 for 2 cycles, in_allowin=0, stall_cnt=2. Then ready=1 with data 0x55 -> out_valid=1, src1=0x55 in that same cycle.
4. Zero register: raddr1=0, stage0 targets r0 unready, rf_rdata1=0xDEAD -> src1=0, no stall.
5. Flush: during a load-use stall, assert flush together with in_valid -> next cycle valid=0, new bundle not captured, stall_cnt unchanged in the flush cycle.
6. Saturation and back-pressure: CW=2, hold a stall 6 cycles -> stall_cnt=3. Separately, out_allowin=0 for 3 cycles -> out_pc/out_inst stable, in_allowin=0.
